// File: rtl/fir_decim_engine.sv
// Multi-channel polyphase-free FIR decimator: per-channel circular sample banks, one shared MAC,
// and rounded, saturated outputs on a valid/ready stream.
module fir_decim_engine #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned COEF_W      = 16,
    parameter int unsigned COEF_FRAC   = 15,
    parameter int unsigned OUT_W       = 16,
    parameter int unsigned NR_TAPS     = 32,
    parameter int unsigned DECIM       = 4,
    parameter int unsigned NR_CHANNELS = 2,
    localparam int unsigned TAP_W      = $clog2(NR_TAPS),
    localparam int unsigned CH_W       = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_data_in_valid,
    output logic              io_data_in_ready,
    input  logic [DATA_W-1:0] io_data_in_payload,
    output logic              io_data_out_valid,
    input  logic              io_data_out_ready,
    output logic [OUT_W-1:0]  io_data_out_payload,
    output logic [CH_W-1:0]   io_data_out_chan,
    input  logic              io_coef_wr_valid,
    output logic              io_coef_wr_ready,
    input  logic [TAP_W-1:0]  io_coef_wr_addr,
    input  logic [COEF_W-1:0] io_coef_wr_data
);

    localparam int unsigned PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + TAP_W;
    localparam int unsigned RND_W  = ACC_W + 1;

    localparam logic [TAP_W-1:0]        TAP_LAST = TAP_W'(NR_TAPS - 1);
    localparam logic [CH_W-1:0]         CH_LAST  = CH_W'(NR_CHANNELS - 1);
    localparam logic [PH_W-1:0]         PH_LAST  = PH_W'(DECIM - 1);
    localparam logic signed [RND_W-1:0] HALF     = RND_W'(1) << (COEF_FRAC - 1);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_MAC, S_ROUND, S_OUT} state_e;

    state_e                    state_q, state_d;
    logic [TAP_W-1:0]          clr_q, clr_d;
    logic [TAP_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CH_W-1:0]           in_chan_q, in_chan_d;
    logic [PH_W-1:0]           phase_q, phase_d;
    logic [CH_W-1:0]           mac_chan_q, mac_chan_d;
    logic [TAP_W-1:0]          tap_q, tap_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [OUT_W-1:0]   res_q, res_d;
    logic [CH_W-1:0]           res_chan_q, res_chan_d;
    logic                      rdy_q, rdy_d;
    logic                      vld_q, vld_d;

    logic signed [DATA_W-1:0]  bank_q [NR_CHANNELS][NR_TAPS];
    logic signed [COEF_W-1:0]  coef_q [NR_TAPS];

    logic                      clr_we, smp_we, coef_we;
    logic [TAP_W-1:0]          rd_idx;
    logic signed [DATA_W-1:0]  smp_rd;
    logic signed [PROD_W-1:0]  prod;
    logic signed [RND_W-1:0]   rnd_sum, rnd_shr;
    logic signed [OUT_W-1:0]   sat_res;

    // Tap k reads the k-th most recent sample; wr_ptr already points one past the newest.
    always_comb begin
        rd_idx = wr_ptr_q - TAP_W'(1) - tap_q;
        smp_rd = bank_q[mac_chan_q][rd_idx];
        prod   = PROD_W'(coef_q[tap_q]) * PROD_W'(smp_rd);
    end

    // Round half up, then clamp when the shifted result does not fit OUT_W.
    always_comb begin
        rnd_sum = RND_W'(acc_q) + HALF;
        rnd_shr = rnd_sum >>> COEF_FRAC;
        if ((&rnd_shr[RND_W-1:OUT_W-1]) || !(|rnd_shr[RND_W-1:OUT_W-1])) begin
            sat_res = rnd_shr[OUT_W-1:0];
        end else if (rnd_shr[RND_W-1]) begin
            sat_res = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_res = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_d      = clr_q;
        wr_ptr_d   = wr_ptr_q;
        in_chan_d  = in_chan_q;
        phase_d    = phase_q;
        mac_chan_d = mac_chan_q;
        tap_d      = tap_q;
        acc_d      = acc_q;
        res_d      = res_q;
        res_chan_d = res_chan_q;
        clr_we     = 1'b0;
        smp_we     = 1'b0;
        coef_we    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we = 1'b1;
                clr_d  = clr_q + TAP_W'(1);
                if (clr_q == TAP_LAST) state_d = S_IDLE;
            end
            S_IDLE: begin
                coef_we = io_coef_wr_valid;
                if (io_data_in_valid) begin
                    smp_we = 1'b1;
                    if (in_chan_q == CH_LAST) begin
                        in_chan_d = '0;
                        wr_ptr_d  = wr_ptr_q + TAP_W'(1);
                        if (phase_q == PH_LAST) begin
                            phase_d    = '0;
                            mac_chan_d = '0;
                            tap_d      = '0;
                            acc_d      = '0;
                            state_d    = S_MAC;
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end else begin
                        in_chan_d = in_chan_q + CH_W'(1);
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                tap_d = tap_q + TAP_W'(1);
                if (tap_q == TAP_LAST) state_d = S_ROUND;
            end
            S_ROUND: begin
                res_d      = sat_res;
                res_chan_d = mac_chan_q;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (io_data_out_ready) begin
                    if (mac_chan_q == CH_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        mac_chan_d = mac_chan_q + CH_W'(1);
                        tap_d      = '0;
                        acc_d      = '0;
                        state_d    = S_MAC;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
        rdy_d = (state_d == S_IDLE);
        vld_d = (state_d == S_OUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_CLEAR;
            clr_q      <= '0;
            wr_ptr_q   <= '0;
            in_chan_q  <= '0;
            phase_q    <= '0;
            mac_chan_q <= '0;
            tap_q      <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            res_chan_q <= '0;
            rdy_q      <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            wr_ptr_q   <= wr_ptr_d;
            in_chan_q  <= in_chan_d;
            phase_q    <= phase_d;
            mac_chan_q <= mac_chan_d;
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            res_chan_q <= res_chan_d;
            rdy_q      <= rdy_d;
            vld_q      <= vld_d;
        end
    end

    // Storage is not reset; the CLEAR sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            for (int unsigned c = 0; c < NR_CHANNELS; c++) begin
                bank_q[CH_W'(c)][clr_q] <= '0;
            end
            coef_q[clr_q] <= '0;
        end else begin
            if (smp_we) bank_q[in_chan_q][wr_ptr_q] <= io_data_in_payload;
            if (coef_we) coef_q[io_coef_wr_addr] <= io_coef_wr_data;
        end
    end

    assign io_data_in_ready    = rdy_q;
    assign io_coef_wr_ready    = rdy_q;
    assign io_data_out_valid   = vld_q;
    assign io_data_out_payload = res_q;
    assign io_data_out_chan    = res_chan_q;

endmodule

// File: tb/tb_fir_decim_engine.sv
// Directed bench for fir_decim_engine: vector table of decimation blocks plus hand-written
// sequences for clear timing, latency, coefficient/sample collision, back-pressure and reset abort.
module tb_fir_decim_engine;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned COEF_W  = 16;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned NR_TAPS = 32;
    localparam int unsigned TAP_W   = 5;
    localparam int          TMO     = 400;
    localparam int          NV      = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              io_data_in_valid = 1'b0;
    logic              io_data_in_ready;
    logic [DATA_W-1:0] io_data_in_payload = '0;
    logic              io_data_out_valid;
    logic              io_data_out_ready = 1'b1;
    logic [OUT_W-1:0]  io_data_out_payload;
    logic [0:0]        io_data_out_chan;
    logic              io_coef_wr_valid = 1'b0;
    logic              io_coef_wr_ready;
    logic [TAP_W-1:0]  io_coef_wr_addr = '0;
    logic [COEF_W-1:0] io_coef_wr_data = '0;

    always #5 clk = ~clk;

    fir_decim_engine dut (
        .clk                 (clk),
        .reset               (reset),
        .io_data_in_valid    (io_data_in_valid),
        .io_data_in_ready    (io_data_in_ready),
        .io_data_in_payload  (io_data_in_payload),
        .io_data_out_valid   (io_data_out_valid),
        .io_data_out_ready   (io_data_out_ready),
        .io_data_out_payload (io_data_out_payload),
        .io_data_out_chan    (io_data_out_chan),
        .io_coef_wr_valid    (io_coef_wr_valid),
        .io_coef_wr_ready    (io_coef_wr_ready),
        .io_coef_wr_addr     (io_coef_wr_addr),
        .io_coef_wr_data     (io_coef_wr_data)
    );

    typedef struct { int ch; int val; } obs_t;
    typedef struct { int cset; int in0; int in1; int exp0; int exp1; } vec_t;

    obs_t obs_q[$];
    vec_t vec[NV];
    int   n_chk = 0;
    int   n_fail = 0;

    // Every completed output handshake is captured here.
    always @(negedge clk) begin
        if (reset && io_data_out_valid && io_data_out_ready)
            obs_q.push_back('{int'(io_data_out_chan), int'($signed(io_data_out_payload))});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout, expected handshake within %0d cycles", name, TMO);
    endtask

    task automatic do_reset();
        int cnt = 0;
        int bad = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        io_data_in_valid  = 1'b0;
        io_coef_wr_valid  = 1'b0;
        io_data_out_ready = 1'b1;
        #1 check("reset_outputs_zero",
                 int'({io_data_in_ready, io_coef_wr_ready, io_data_out_valid,
                       io_data_out_chan, io_data_out_payload}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        while (!io_data_in_ready && cnt < TMO) begin
            if (io_coef_wr_ready || io_data_out_valid) bad++;
            cnt++;
            @(negedge clk);
        end
        check("clear_cycles", cnt, int'(NR_TAPS));
        check("clear_quiet", bad, 0);
        check("idle_coef_ready", int'(io_coef_wr_ready), 1);
        obs_q.delete();
    endtask

    task automatic send_sample(input int d);
        int n = 0;
        @(negedge clk);
        io_data_in_valid   = 1'b1;
        io_data_in_payload = 16'(d);
        while (!io_data_in_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!io_data_in_ready) begin
            timeout_fail("in_accept");
            io_data_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 io_data_in_valid = 1'b0;
    endtask

    task automatic send_with_coef(input int d, input int a, input int c);
        int n = 0;
        @(negedge clk);
        io_data_in_valid   = 1'b1;
        io_data_in_payload = 16'(d);
        io_coef_wr_valid   = 1'b1;
        io_coef_wr_addr    = 5'(a);
        io_coef_wr_data    = 16'(c);
        while (!io_data_in_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!io_data_in_ready) timeout_fail("collide_accept");
        @(posedge clk);
        #1 io_data_in_valid = 1'b0;
        io_coef_wr_valid = 1'b0;
    endtask

    task automatic write_coef(input int a, input int c);
        int n = 0;
        @(negedge clk);
        io_coef_wr_valid = 1'b1;
        io_coef_wr_addr  = 5'(a);
        io_coef_wr_data  = 16'(c);
        while (!io_coef_wr_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!io_coef_wr_ready) timeout_fail("coef_accept");
        @(posedge clk);
        #1 io_coef_wr_valid = 1'b0;
    endtask

    task automatic send_block(input int a, input int b);
        repeat (4) begin
            send_sample(a);
            send_sample(b);
        end
    endtask

    task automatic load_cset(input int cs);
        case (cs)
            0: write_coef(0, 16'h4000);
            1: for (int i = 0; i < int'(NR_TAPS); i++) write_coef(i, 1024);
            2: write_coef(0, 1);
            default: for (int i = 0; i < int'(NR_TAPS); i++) write_coef(i, 16'h7FFF);
        endcase
    endtask

    task automatic expect_out(input string name, input int ch, input int val);
        int   n = 0;
        obs_t o;
        while (obs_q.size() == 0 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (obs_q.size() == 0) begin
            timeout_fail({name, "_wait"});
        end else begin
            o = obs_q.pop_front();
            check({name, "_chan"}, o.ch, ch);
            check({name, "_data"}, o.val, val);
        end
    endtask

    initial begin
        int lat;
        int gap;
        int bad;
        logic [OUT_W-1:0] hold_data;
        logic [0:0]       hold_chan;

        // cset 0: coef[0]=0.5; cset 1: all 1/32; cset 2: coef[0]=2^-15; cset 3: all 0x7FFF
        vec[0] = '{0, 4096, -4096, 2048, -2048};
        vec[1] = '{0, 4096, -4096, 2048, -2048};
        for (int k = 1; k <= 8; k++) vec[1 + k] = '{1, 4096, -2048, 512 * k, -256 * k};
        vec[10] = '{1, 4096, -2048, 4096, -2048};
        vec[11] = '{2, 16384, -16384, 1, 0};
        vec[12] = '{2, 16383, -16385, 0, -1};
        vec[13] = '{3, 32767, -32768, 32767, -32768};
        vec[14] = '{3, -32768, 32767, -4, -4};
        vec[15] = '{3, -32768, 32767, -32768, 32767};

        for (int i = 0; i < NV; i++) begin
            if (i == 0 || vec[i].cset != vec[i - 1].cset) begin
                do_reset();
                load_cset(vec[i].cset);
            end
            send_block(vec[i].in0, vec[i].in1);
            expect_out($sformatf("vec%0d_ch0", i), 0, vec[i].exp0);
            expect_out($sformatf("vec%0d_ch1", i), 1, vec[i].exp1);
        end

        // Coefficient rewrite landing on the triggering accept, plus output latency.
        do_reset();
        load_cset(0);
        repeat (3) begin
            send_sample(4096);
            send_sample(-4096);
        end
        send_sample(4096);
        send_with_coef(-4096, 0, 16'h2000);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!io_data_out_valid && lat < TMO);
        check("latency_first", lat, int'(NR_TAPS) + 2);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!(io_data_out_valid && io_data_out_chan == 1'b1) && gap < TMO);
        check("latency_next_chan", gap, int'(NR_TAPS) + 2);
        expect_out("collide_ch0", 0, 1024);
        expect_out("collide_ch1", 1, -1024);

        // Back-pressure: output held 100 cycles while upstream keeps offering samples.
        @(posedge clk);
        #1 io_data_out_ready = 1'b0;
        send_block(8000, -8000);
        lat = 0;
        while (!io_data_out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        check("stall_valid", int'(io_data_out_valid), 1);
        hold_data = io_data_out_payload;
        hold_chan = io_data_out_chan;
        check("stall_payload", int'($signed(hold_data)), 2000);
        check("stall_chan", int'(hold_chan), 0);
        fork
            send_block(3000, -3000);
        join_none
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (io_data_out_payload !== hold_data || io_data_out_chan !== hold_chan ||
                !io_data_out_valid || io_data_in_ready)
                bad++;
        end
        check("stall_stable", bad, 0);
        check("stall_no_early_out", obs_q.size(), 0);
        @(posedge clk);
        #1 io_data_out_ready = 1'b1;
        expect_out("stall_rel_ch0", 0, 2000);
        expect_out("stall_rel_ch1", 1, -2000);
        expect_out("stall_next_ch0", 0, 750);
        expect_out("stall_next_ch1", 1, -750);
        wait fork;

        // Reset in the middle of a MAC aborts it; clear reruns and the basic case works again.
        send_block(4096, -4096);
        repeat (10) @(negedge clk);
        do_reset();
        load_cset(0);
        send_block(4096, -4096);
        expect_out("post_reset_ch0", 0, 2048);
        expect_out("post_reset_ch1", 1, -2048);
        repeat (5) @(negedge clk);
        check("post_reset_no_extra", obs_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
